// File: rtl/jtframe_dump_ctrl_if.sv
// Bundle between the test harness and the dump window scheduler: sync/download
// inputs plus the frame counter, window flags and state.
interface jtframe_dump_ctrl_if #(
  parameter int unsigned FCNT_W = 32
) ();
  logic              vs;
  logic              downloading;
  logic [FCNT_W-1:0] frame_cnt;
  logic              dump_on;
  logic              dump_start;
  logic              dump_stop;
  logic [1:0]        st;

  modport master (
    output vs, downloading,
    input  frame_cnt, dump_on, dump_start, dump_stop, st
  );

  modport slave (
    input  vs, downloading,
    output frame_cnt, dump_on, dump_start, dump_stop, st
  );
endinterface

// File: rtl/jtframe_dump_ctrl.sv
// Frame-window scheduler for waveform capture: counts vsync falls and holds dump_on
// between START_FRAME and STOP_FRAME. Define JTFRAME_DUMP_DLWAIT_EN to gate on ROM download.
module jtframe_dump_ctrl #(
  parameter int unsigned      FCNT_W      = 32,
  parameter longint unsigned  START_FRAME = 0,
  parameter longint unsigned  STOP_FRAME  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  jtframe_dump_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    WAIT_DL = 2'd0,
    COUNT   = 2'd1,
    DUMPING = 2'd2,
    DONE    = 2'd3
  } state_e;

`ifdef JTFRAME_DUMP_DLWAIT_EN
  localparam state_e RST_ST = WAIT_DL;
`else
  localparam state_e RST_ST = COUNT;
`endif

  localparam logic [FCNT_W-1:0] CNT_MAX = '1;

  state_e            st_q, st_d;
  logic [FCNT_W-1:0] cnt_q, cnt_d;
  logic              vs_l_q;
  logic              dump_on_q, dump_on_d;
  logic              start_q, start_d;
  logic              stop_q, stop_d;
  logic              vs_fall;
  logic [63:0]       cnt_ext;

  assign vs_fall = vs_l_q & ~bus.vs;
  assign cnt_ext = 64'(cnt_q);

`ifdef JTFRAME_DUMP_DLWAIT_EN
  logic dl_l_q, dl_seen_q;
  logic dl_fall;

  assign dl_fall = dl_l_q & ~bus.downloading;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_l_q    <= 1'b0;
      dl_seen_q <= 1'b0;
    end else begin
      dl_l_q <= bus.downloading;
      if (bus.downloading) dl_seen_q <= 1'b1;
    end
  end
`else
  logic unused_downloading;
  assign unused_downloading = bus.downloading;
`endif

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;

    // The counter runs in every state but WAIT_DL and sticks at all-ones.
    if (vs_fall && st_q != WAIT_DL && cnt_q != CNT_MAX) cnt_d = cnt_q + FCNT_W'(1);

    case (st_q)
`ifdef JTFRAME_DUMP_DLWAIT_EN
      WAIT_DL: begin
        if (dl_fall && dl_seen_q) begin
          st_d  = COUNT;
          cnt_d = '0;
        end
      end
`endif
      COUNT: begin
        if (START_FRAME == 0 || (vs_fall && cnt_ext >= START_FRAME)) st_d = DUMPING;
      end
      DUMPING: begin
        if (STOP_FRAME != 0 && vs_fall && cnt_ext >= STOP_FRAME) st_d = DONE;
      end
      default: ;
    endcase

`ifdef JTFRAME_DUMP_DLWAIT_EN
    // A new download overrides everything and restarts the schedule.
    if (bus.downloading && st_q != WAIT_DL) begin
      st_d  = WAIT_DL;
      cnt_d = '0;
    end
`endif

    dump_on_d = (st_d == DUMPING);
    start_d   = (st_q != DUMPING) && (st_d == DUMPING);
    stop_d    = (st_q == DUMPING) && (st_d != DUMPING);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= RST_ST;
      cnt_q     <= '0;
      vs_l_q    <= 1'b0;
      dump_on_q <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      vs_l_q    <= bus.vs;
      dump_on_q <= dump_on_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
    end
  end

  assign bus.frame_cnt  = cnt_q;
  assign bus.dump_on    = dump_on_q;
  assign bus.dump_start = start_q;
  assign bus.dump_stop  = stop_q;
  assign bus.st         = st_q;

endmodule

// File: tb/tb_jtframe_dump_ctrl.sv
// Scoreboard bench for jtframe_dump_ctrl: three instances (3..5 window, open window,
// 4-bit saturating counter) share one vsync; a monitor checks every start/stop pulse.
`timescale 1ns/1ps
module tb_jtframe_dump_ctrl;

`ifdef JTFRAME_DUMP_DLWAIT_EN
  localparam bit DL_EN = 1'b1;
`else
  localparam bit DL_EN = 1'b0;
`endif
  localparam logic [63:0] RST_ST = DL_EN ? 64'd0 : 64'd1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vs = 1'b0;
  logic downloading = 1'b0;

  always #5 clk = ~clk;

  jtframe_dump_ctrl_if #(.FCNT_W(32)) if_a ();
  jtframe_dump_ctrl_if #(.FCNT_W(32)) if_b ();
  jtframe_dump_ctrl_if #(.FCNT_W(4))  if_c ();

  assign if_a.vs = vs;  assign if_a.downloading = downloading;
  assign if_b.vs = vs;  assign if_b.downloading = downloading;
  assign if_c.vs = vs;  assign if_c.downloading = downloading;

  jtframe_dump_ctrl #(.FCNT_W(32), .START_FRAME(3),  .STOP_FRAME(5)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  jtframe_dump_ctrl #(.FCNT_W(32), .START_FRAME(0),  .STOP_FRAME(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  jtframe_dump_ctrl #(.FCNT_W(4),  .START_FRAME(20), .STOP_FRAME(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  typedef struct {
    int          dut;
    bit          is_start;
    logic [63:0] cnt;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  on_cycles_a = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int d, input bit is_start, input logic [63:0] cnt);
    ev_t e;
    e.dut = d;  e.is_start = is_start;  e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic mon_one(input int d, input logic st, input logic sp, input logic [63:0] cnt);
    int idx;
    idx = -1;
    if (st || sp) begin
      check($sformatf("dut%0d_start_stop_exclusive", d), 64'(st & sp), 64'd0);
      for (int i = 0; i < exp_q.size(); i++)
        if (idx < 0 && exp_q[i].dut == d) idx = i;
      if (idx < 0) begin
        checks++;
        errors++;
        $display("FAIL dut%0d_unexpected_pulse: got start=%0b stop=%0b cnt=%0d expected no pulse", d, st, sp, cnt);
      end else begin
        check($sformatf("dut%0d_pulse_kind", d), 64'(st), 64'(exp_q[idx].is_start));
        check($sformatf("dut%0d_pulse_cnt", d), cnt, exp_q[idx].cnt);
        exp_q.delete(idx);
      end
    end
  endtask

  // Monitor: decoupled from stimulus, samples on the falling edge.
  always @(negedge clk) begin
    mon_one(0, if_a.dump_start, if_a.dump_stop, 64'(if_a.frame_cnt));
    mon_one(1, if_b.dump_start, if_b.dump_stop, 64'(if_b.frame_cnt));
    mon_one(2, if_c.dump_start, if_c.dump_stop, 64'(if_c.frame_cnt));
    if (if_a.dump_on) on_cycles_a++;
  end

  // One frame = 100 clocks, vs high for 10; starts and ends on a falling edge.
  task automatic run_frames(input int n);
    for (int k = 0; k < n; k++) begin
      vs = 1'b1;
      repeat (10) @(negedge clk);
      vs = 1'b0;
      repeat (90) @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("a_rst_frame_cnt", 64'(if_a.frame_cnt), 64'd0);
    check("a_rst_dump_on",   64'(if_a.dump_on),   64'd0);
    check("a_rst_start",     64'(if_a.dump_start), 64'd0);
    check("a_rst_stop",      64'(if_a.dump_stop),  64'd0);
    check("a_rst_st",        64'(if_a.st),        RST_ST);
    check("c_rst_st",        64'(if_c.st),        RST_ST);

    push(0, 1'b1, 64'd4);
    push(0, 1'b0, 64'd6);
`ifndef JTFRAME_DUMP_DLWAIT_EN
    push(1, 1'b1, 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
`ifndef JTFRAME_DUMP_DLWAIT_EN
    check("b_dump_on_two_edges", 64'(if_b.dump_on), 64'd1);
`else
    check("b_wait_dl_dump_on", 64'(if_b.dump_on), 64'd0);
    downloading = 1'b1;
    run_frames(2);
    check("a_cnt_during_dl", 64'(if_a.frame_cnt), 64'd0);
    check("b_cnt_during_dl", 64'(if_b.frame_cnt), 64'd0);
    check("b_st_during_dl",  64'(if_b.st),        64'd0);
    push(1, 1'b1, 64'd0);
    downloading = 1'b0;
    repeat (5) @(negedge clk);
`endif

    run_frames(18);
    check("a_cnt_after_18", 64'(if_a.frame_cnt), 64'd18);
    check("a_st_done",      64'(if_a.st),        64'd3);
    check("a_dump_on_off",  64'(if_a.dump_on),   64'd0);
    check("b_cnt_after_18", 64'(if_b.frame_cnt), 64'd18);
    check("b_dump_on_held", 64'(if_b.dump_on),   64'd1);
    check("c_cnt_saturated", 64'(if_c.frame_cnt), 64'd15);
    check("c_st_count",     64'(if_c.st),        64'd1);
    check("c_dump_on_never", 64'(if_c.dump_on),  64'd0);

`ifdef JTFRAME_DUMP_DLWAIT_EN
    // Download reasserted mid-window: b closes its window, everything restarts.
    push(1, 1'b0, 64'd0);
    downloading = 1'b1;
    @(negedge clk);
    check("b_st_redl",  64'(if_b.st),        64'd0);
    check("b_cnt_redl", 64'(if_b.frame_cnt), 64'd0);
    check("a_st_redl",  64'(if_a.st),        64'd0);
    repeat (20) @(negedge clk);
    push(1, 1'b1, 64'd0);
    push(0, 1'b1, 64'd4);
    push(0, 1'b0, 64'd6);
    downloading = 1'b0;
    repeat (5) @(negedge clk);
    run_frames(7);
    check("a_cnt_after_repeat", 64'(if_a.frame_cnt), 64'd7);
    check("b_dump_on_repeat",   64'(if_b.dump_on),   64'd1);
`endif

    // Asynchronous reset in the middle of b's window; vs is held low.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("b_async_dump_on",   64'(if_b.dump_on),   64'd0);
    check("b_async_stop",      64'(if_b.dump_stop), 64'd0);
    check("b_async_frame_cnt", 64'(if_b.frame_cnt), 64'd0);
    check("b_async_st",        64'(if_b.st),        RST_ST);
    check("a_async_st",        64'(if_a.st),        RST_ST);
`ifndef JTFRAME_DUMP_DLWAIT_EN
    push(1, 1'b1, 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("b_dump_on_after_rst", 64'(if_b.dump_on), DL_EN ? 64'd0 : 64'd1);
    check("a_dump_on_after_rst", 64'(if_a.dump_on), 64'd0);
    repeat (5) @(negedge clk);

    check("a_window_clocks", 64'(on_cycles_a), DL_EN ? 64'd400 : 64'd200);
    check("pending_expected_pulses", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
